reduce_unit_arbiter: RTL
========================

Name: reduce_unit_arbiter

Overview:
- Round-robin scheduler that shares one combinational arithmetic-reduce unit among NUM_REQ requesters.
- Interface to the unit: 8-bit operands p/q out; complex_expr, red_and_res, red_or_res back.
- Sits between requester ports and the single shared unit instance.
- Registers the operands, samples the unit outputs one cycle later, and returns a tagged response over a valid/ready channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_W is the internal localparam $clog2(NUM_REQ).
- DATA_W, 8, operand and complex_expr width.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester operand valid
- req_ready  output  NUM_REQ  one-hot accept; combinational from req_valid, state and pointer
- req_p  input  NUM_REQ*DATA_W  packed p operands; requester i at [i*DATA_W +: DATA_W]
- req_q  input  NUM_REQ*DATA_W  packed q operands, same packing
- unit_p  output  DATA_W  registered p to shared unit
- unit_q  output  DATA_W  registered q to shared unit
- unit_expr  input  DATA_W  unit complex_expr result
- unit_and  input  1  unit red_and_res
- unit_or  input  1  unit red_or_res
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  ID_W  index of the requester being answered
- rsp_expr  output  DATA_W  captured complex_expr
- rsp_and  output  1  captured red_and_res
- rsp_or  output  1  captured red_or_res
- busy  output  1  high in EVAL or RESP

Behaviour:
- FSM states and transitions:
  - IDLE: accept when any req_valid → EVAL.
  - EVAL: always → RESP.
  - RESP: on rsp_ready with any req_valid, accept → EVAL; on rsp_ready with none valid → IDLE; else hold.
- Accept is allowed only in IDLE, or in RESP with rsp_ready=1.
  - Winner: first valid index searching ptr+1, ptr+2, ... with modulo NUM_REQ wrap.
  - req_ready[winner]=1 in that cycle; all other bits 0.
  - On the accept edge: unit_p/unit_q load the winner's operands, gnt_id=winner, ptr=winner.
- EVAL: unit_p/unit_q are stable. At the end of the cycle, unit_expr/and/or are captured into rsp_expr/and/or, rsp_id=gnt_id, rsp_valid set.
- Latency: accept in cycle T → rsp_valid=1 in T+2. Maximum throughput is one transaction per 2 cycles.
- RESP: rsp_* held stable until rsp_valid&&rsp_ready.
  - rsp_valid drops the cycle after handshake, unless a new accept occurred in the same cycle; then it drops for one cycle (EVAL) and rises again.
- Requester protocol: once req_valid rises, the requester holds it and its operands until accepted. The block never samples unaccepted operands.
- unit_p/unit_q keep their last value in IDLE/RESP (no toggling).
- Reset (synchronous, any state including mid-EVAL/RESP):
  - state=IDLE, ptr=NUM_REQ-1 (first search starts at 0).
  - unit_p=unit_q=0, rsp_valid=0, rsp_id=0, rsp_expr=0, rsp_and=0, rsp_or=0, busy=0.
  - req_ready=0 during reset.
  - An in-flight transaction is dropped with no response.
- Simultaneous events: RESP handshake plus new valid in the same cycle is legal. The accept is based on the pointer value before update.

Optional Feature:
- Macro: REDUCE_ARB_FIXED_PRIO_EN.
- Defined: the winner is always the lowest valid index; ptr is not used. Latency and FSM are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Bench unit model for all scenarios: unit_expr=unit_p^unit_q, unit_and=&unit_p, unit_or=|unit_q.
- Single request (NUM_REQ=4): req_valid=4'b0100, p=0x12, q=0x34, rsp_ready=1 → req_ready=4'b0100 in cycle T; in T+2 rsp_valid=1, rsp_id=2, rsp_expr=0x26, rsp_and=0, rsp_or=1; IDLE in T+3.
- All four valid continuously, rsp_ready=1 → accepts at T, T+2, T+4, T+6, T+8 with ids 0,1,2,3,0; rsp_valid pattern 1,0,1,0 from T+2.
- Backpressure: response pending with rsp_ready=0 for 5 cycles, req_valid=4'b1111 → rsp_* constant, req_ready=0, busy=1. Raising rsp_ready gives a handshake and the next id accepted in the same cycle.
- Wrap fairness: grant id 3 (p=0xFF, q=0x00 → rsp_and=1, rsp_or=0), then req_valid=4'b1001 → next grant id 0, then id 3.
- Reset asserted in the EVAL cycle → next cycle rsp_valid=0, busy=0, unit_p=0. After release with req_valid=4'b1111 → first grant id 0; no stale response appears.
- With REDUCE_ARB_FIXED_PRIO_EN defined and req_valid=4'b1010 held → grants id 1 repeatedly; id 3 is granted only after req_valid[1] drops.

Source files
------------

// File: rtl/reduce_unit_arbiter.sv
// rtl/reduce_unit_arbiter.sv - round-robin scheduler sharing one combinational reduce unit among NUM_REQ requesters
// Define REDUCE_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins priority.
module reduce_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_p,
    input  logic [NUM_REQ*DATA_W-1:0] req_q,
    output logic [DATA_W-1:0]         unit_p,
    output logic [DATA_W-1:0]         unit_q,
    input  logic [DATA_W-1:0]         unit_expr,
    input  logic                      unit_and,
    input  logic                      unit_or,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_expr,
    output logic                      rsp_and,
    output logic                      rsp_or,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t              state_q;
    logic [ID_W-1:0]     gnt_id_q;
    logic [DATA_W-1:0]   unit_p_q;
    logic [DATA_W-1:0]   unit_q_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_expr_q;
    logic                rsp_and_q;
    logic                rsp_or_q;
    logic                busy_q;

    logic [ID_W-1:0]     winner;
    logic                found;
    logic                accept;

`ifdef REDUCE_ARB_FIXED_PRIO_EN
    always_comb begin
        found  = 1'b0;
        winner = '0;
        // Descending scan so the lowest valid index is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[ID_W'(i)]) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0]     ptr_q;
    logic [ID_W-1:0]     cand;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        // Search starts one past the last grant so the last winner has lowest priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end
`endif

    assign accept = found && !rst &&
                    ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_id_q    <= '0;
            unit_p_q    <= '0;
            unit_q_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_expr_q  <= '0;
            rsp_and_q   <= 1'b0;
            rsp_or_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifndef REDUCE_ARB_FIXED_PRIO_EN
            ptr_q       <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            if (accept) begin
                unit_p_q <= req_p[int'(winner)*DATA_W +: DATA_W];
                unit_q_q <= req_q[int'(winner)*DATA_W +: DATA_W];
                gnt_id_q <= winner;
`ifndef REDUCE_ARB_FIXED_PRIO_EN
                ptr_q    <= winner;
`endif
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= EVAL;
                        busy_q  <= 1'b1;
                    end
                end
                EVAL: begin
                    rsp_expr_q  <= unit_expr;
                    rsp_and_q   <= unit_and;
                    rsp_or_q    <= unit_or;
                    rsp_id_q    <= gnt_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (accept) begin
                            state_q <= EVAL;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign unit_p    = unit_p_q;
    assign unit_q    = unit_q_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_expr  = rsp_expr_q;
    assign rsp_and   = rsp_and_q;
    assign rsp_or    = rsp_or_q;
    assign busy      = busy_q;

endmodule
